bcp_host_ctrl: RTL and testbench

BCP_HOST_CTRL -- requirements
Module: bcp_host_ctrl

---
 rtl/bcp_host_ctrl_if.sv | 58 +++++
 rtl/bcp_host_ctrl.sv | 145 ++++++++++++++
 tb/tb_bcp_host_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcp_host_ctrl_if.sv
// Host-side bus of the BCP controller: command channel, core strobes, implied-literal
// stack, result stream and solve control/status.
interface bcp_host_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int NODE_W = 40,
    parameter int PTR_W  = 24,
    parameter int LIT_W  = 16
);
    typedef logic [NODE_W-1:0] node_t;
    typedef logic [PTR_W-1:0]  dummy_entry_t;
    typedef logic [LIT_W-1:0]  lit_t;

    logic              start;
    logic              clear;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_type;
    logic [DATA_W-1:0] cmd_data;
    node_t             node_in;
    logic              node_in_valid;
    dummy_entry_t      dummy_ptr;
    logic              dummy_ptr_valid;
    logic              change_eng;
    lit_t              mem2uca;
    logic              mem2uca_valid;
    logic              mem2uca_done;
    logic              halt;
    logic              conflict;
    logic              stall;
    logic              mstack_empty;
    lit_t              mstack_lit;
    logic              mstack_pop;
    logic              res_valid;
    logic              res_ready;
    lit_t              res_lit;
    logic              done;
    logic [1:0]        status;
    logic              bad_cmd;
    logic [15:0]       lit_cnt;

    // Host / core environment side
    modport master (
        output start, clear, cmd_valid, cmd_type, cmd_data,
               conflict, stall, mstack_empty, mstack_lit, res_ready,
        input  cmd_ready, node_in, node_in_valid, dummy_ptr, dummy_ptr_valid,
               change_eng, mem2uca, mem2uca_valid, mem2uca_done, halt,
               mstack_pop, res_valid, res_lit, done, status, bad_cmd, lit_cnt
    );

    // Controller side
    modport slave (
        input  start, clear, cmd_valid, cmd_type, cmd_data,
               conflict, stall, mstack_empty, mstack_lit, res_ready,
        output cmd_ready, node_in, node_in_valid, dummy_ptr, dummy_ptr_valid,
               change_eng, mem2uca, mem2uca_valid, mem2uca_done, halt,
               mstack_pop, res_valid, res_lit, done, status, bad_cmd, lit_cnt
    );
endinterface

// File: rtl/bcp_host_ctrl.sv
// BCP host controller: loads clauses/pointers/unit literals into the core, runs it
// until conflict, quiescence or timeout, then drains the implied-literal stack.
module bcp_host_ctrl #(
    parameter int STALL_CYC = 4,
    parameter int TIMEOUT   = 65535,
    parameter int DATA_W    = 64,
    parameter int NODE_W    = 40,
    parameter int PTR_W     = 24,
    parameter int LIT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bcp_host_ctrl_if.slave  bus
);
    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam int STL_W = $clog2(STALL_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;
    typedef enum logic [2:0] {
        CMD_CLAUSE = 3'd0, CMD_PTR = 3'd1, CMD_CHANGE_ENG = 3'd2,
        CMD_UNIT_LIT = 3'd3, CMD_UNIT_DONE = 3'd4
    } cmd_e;

    state_e             state, state_nxt;
    logic [RUN_W-1:0]   run_cnt, run_nxt;
    logic [STL_W-1:0]   stall_cnt, stall_nxt;
    logic [1:0]         exit_code;
    logic               accept, pop;

    logic [NODE_W-1:0]  node_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [LIT_W-1:0]   lit_q;
    logic               node_vld_q, ptr_vld_q, chg_q, lit_vld_q, lit_done_q;
    logic [1:0]         status_q;
    logic               bad_q;
    logic [15:0]        lit_cnt_q;

    generate
        if (DATA_W > NODE_W) begin : g_unused
            logic unused_data_hi;
            assign unused_data_hi = ^bus.cmd_data[DATA_W-1:NODE_W];
        end
    endgenerate

    assign accept    = (state == LOAD) && bus.cmd_valid;
    assign pop       = (state == DRAIN) && !bus.mstack_empty && bus.res_ready;
    assign run_nxt   = run_cnt + RUN_W'(1);
    assign stall_nxt = bus.stall ? stall_cnt + STL_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Exit priority in RUN: conflict, then quiescence, then timeout.
    always_comb begin
        state_nxt = state;
        exit_code = 2'd0;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = LOAD;
            LOAD:  if (accept && cmd_e'(bus.cmd_type) == CMD_UNIT_DONE) state_nxt = RUN;
            RUN: begin
                if (bus.conflict)                          exit_code = 2'd2;
                else if (stall_nxt == STL_W'(STALL_CYC))   exit_code = 2'd1;
                else if (run_nxt == RUN_W'(TIMEOUT))       exit_code = 2'd3;
                if (exit_code != 2'd0) state_nxt = DRAIN;
            end
            DRAIN: if (bus.mstack_empty) state_nxt = DONE;
            DONE:  if (bus.clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            node_q     <= '0;
            ptr_q      <= '0;
            lit_q      <= '0;
            node_vld_q <= 1'b0;
            ptr_vld_q  <= 1'b0;
            chg_q      <= 1'b0;
            lit_vld_q  <= 1'b0;
            lit_done_q <= 1'b0;
            status_q   <= 2'd0;
            bad_q      <= 1'b0;
            lit_cnt_q  <= '0;
            run_cnt    <= '0;
            stall_cnt  <= '0;
        end else begin
            node_vld_q <= 1'b0;
            ptr_vld_q  <= 1'b0;
            chg_q      <= 1'b0;
            lit_vld_q  <= 1'b0;
            lit_done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    status_q  <= 2'd0;
                    lit_cnt_q <= '0;
                    bad_q     <= 1'b0;
                    run_cnt   <= '0;
                    stall_cnt <= '0;
                end
                LOAD: if (accept) begin
                    case (bus.cmd_type)
                        CMD_CLAUSE:     begin node_q <= bus.cmd_data[NODE_W-1:0]; node_vld_q <= 1'b1; end
                        CMD_PTR:        begin ptr_q  <= bus.cmd_data[PTR_W-1:0];  ptr_vld_q  <= 1'b1; end
                        CMD_CHANGE_ENG: chg_q <= 1'b1;
                        CMD_UNIT_LIT:   begin lit_q  <= bus.cmd_data[LIT_W-1:0];  lit_vld_q  <= 1'b1; end
                        CMD_UNIT_DONE:  begin
                            lit_done_q <= 1'b1;
                            run_cnt    <= '0;
                            stall_cnt  <= '0;
                        end
                        default:        bad_q <= 1'b1;
                    endcase
                end
                RUN: begin
                    run_cnt   <= run_nxt;
                    stall_cnt <= stall_nxt;
                    if (exit_code != 2'd0) status_q <= exit_code;
                end
                DRAIN: if (pop && lit_cnt_q != 16'hFFFF) lit_cnt_q <= lit_cnt_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready       = (state == LOAD);
    assign bus.halt            = (state != RUN);
    assign bus.done            = (state == DONE);
    assign bus.res_valid       = (state == DRAIN) && !bus.mstack_empty;
    assign bus.res_lit         = bus.mstack_lit;
    assign bus.mstack_pop      = pop;
    assign bus.node_in         = node_q;
    assign bus.node_in_valid   = node_vld_q;
    assign bus.dummy_ptr       = ptr_q;
    assign bus.dummy_ptr_valid = ptr_vld_q;
    assign bus.change_eng      = chg_q;
    assign bus.mem2uca         = lit_q;
    assign bus.mem2uca_valid   = lit_vld_q;
    assign bus.mem2uca_done    = lit_done_q;
    assign bus.status          = status_q;
    assign bus.bad_cmd         = bad_q;
    assign bus.lit_cnt         = lit_cnt_q;
endmodule

// File: tb/tb_bcp_host_ctrl.sv
// Directed bench for bcp_host_ctrl with a command/strobe scoreboard and a modelled
// implied-literal stack whose contents are the expected result stream.
module tb_bcp_host_ctrl;
    localparam int DATA_W = 64, NODE_W = 40, PTR_W = 24, LIT_W = 16;

    typedef struct { int kind; logic [63:0] data; } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcp_host_ctrl_if #(.DATA_W(DATA_W), .NODE_W(NODE_W), .PTR_W(PTR_W), .LIT_W(LIT_W)) bus ();

    bcp_host_ctrl #(.STALL_CYC(4), .TIMEOUT(10), .DATA_W(DATA_W), .NODE_W(NODE_W),
                    .PTR_W(PTR_W), .LIT_W(LIT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_cmd[$];
    logic [LIT_W-1:0] exp_res[$];
    logic [LIT_W-1:0] stk[$];
    logic pop_pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_stack();
        bus.mstack_empty = (stk.size() == 0);
        bus.mstack_lit   = (stk.size() == 0) ? '0 : stk[0];
    endtask

    task automatic load_stack(input logic [LIT_W-1:0] l);
        stk.push_back(l);
        exp_res.push_back(l);
        refresh_stack();
    endtask

    // Checks strobes from last cycle's acceptance, records this cycle's acceptance and pops.
    task automatic monitor();
        int ns, k;
        logic [63:0] d, m;
        exp_t e;
        ns = int'(bus.node_in_valid) + int'(bus.dummy_ptr_valid) + int'(bus.change_eng)
           + int'(bus.mem2uca_valid) + int'(bus.mem2uca_done);
        if (ns > 0) begin
            chk("single_strobe", 64'(ns), 64'd1);
            k = bus.node_in_valid ? 0 : bus.dummy_ptr_valid ? 1 : bus.change_eng ? 2 :
                bus.mem2uca_valid ? 3 : 4;
            d = (k == 0) ? 64'(bus.node_in) : (k == 1) ? 64'(bus.dummy_ptr) :
                (k == 3) ? 64'(bus.mem2uca) : 64'd0;
            if (exp_cmd.size() == 0) chk("unexpected_strobe", 64'(ns), 64'd0);
            else begin
                e = exp_cmd.pop_front();
                chk("strobe_kind", 64'(k), 64'(e.kind));
                chk("strobe_data", d, e.data);
            end
        end
        if (bus.cmd_valid && bus.cmd_ready && bus.cmd_type <= 3'd4) begin
            e.kind = int'(bus.cmd_type);
            m = (e.kind == 0) ? ((64'd1 << NODE_W) - 1) : (e.kind == 1) ? ((64'd1 << PTR_W) - 1) :
                (e.kind == 3) ? ((64'd1 << LIT_W) - 1) : 64'd0;
            e.data = bus.cmd_data & m;
            exp_cmd.push_back(e);
        end
        if (bus.mstack_pop) begin
            chk("pop_nonempty", 64'(bus.mstack_empty), 64'd0);
            if (exp_res.size() == 0) chk("unexpected_pop", 64'(bus.mstack_pop), 64'd0);
            else chk("res_lit", 64'(bus.res_lit), 64'(exp_res.pop_front()));
            pop_pend = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pop_pend) begin
            if (stk.size() > 0) void'(stk.pop_front());
            pop_pend = 1'b0;
        end
        refresh_stack();
    endtask

    task automatic send(input logic [2:0] t, input logic [63:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_data  = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic start_solve();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!bus.halt && n < 40) begin tick(); n++; end
        chk(tag, 64'(bus.halt), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 40) begin tick(); n++; end
        chk(tag, 64'(bus.done), 64'd1);
    endtask

    task automatic finish_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clear_to_idle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.start = 0; bus.clear = 0; bus.cmd_valid = 0; bus.cmd_type = 0; bus.cmd_data = 0;
        bus.conflict = 0; bus.stall = 0; bus.res_ready = 0;
        refresh_stack();
        tick(); tick();
        chk("rst_halt", 64'(bus.halt), 64'd1);
        chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_status", 64'(bus.status), 64'd0);
        chk("rst_lit_cnt", 64'(bus.lit_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Load then quiescent drain of {7,9}
        bus.stall = 1'b1;
        load_stack(16'd7); load_stack(16'd9);
        start_solve();
        chk("load_ready", 64'(bus.cmd_ready), 64'd1);
        chk("load_halt", 64'(bus.halt), 64'd1);
        send(3'd0, 64'hFFFF_00AB_CDEF_0123);
        send(3'd0, 64'h0000_0012_3456_789A);
        send(3'd0, 64'h0000_00FF_0000_0001);
        send(3'd1, 64'h0000_0000_00AB_CDEF);
        send(3'd3, 64'd5);
        send(3'd4, 64'd0);
        chk("run_halt0", 64'(bus.halt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run_halt", 64'(bus.halt), 64'd0);
        end
        tick();
        chk("drain_halt", 64'(bus.halt), 64'd1);
        chk("quiet_status", 64'(bus.status), 64'd1);
        chk("drain_valid", 64'(bus.res_valid), 64'd1);
        chk("drain_lit0", 64'(bus.res_lit), 64'd7);
        bus.res_ready = 1'b1;
        wait_done("quiet_done");
        chk("quiet_lit_cnt", 64'(bus.lit_cnt), 64'd2);
        chk("quiet_status_done", 64'(bus.status), 64'd1);
        chk("quiet_res_empty", 64'(exp_res.size()), 64'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("done_ignores_start", 64'(bus.done), 64'd1);
        finish_clear();

        // Conflict on the 3rd RUN cycle together with stall
        start_solve();
        chk("start_clears_status", 64'(bus.status), 64'd0);
        chk("start_clears_cnt", 64'(bus.lit_cnt), 64'd0);
        send(3'd4, 64'd0);
        tick(); tick();
        bus.conflict = 1'b1;
        tick();
        bus.conflict = 1'b0;
        chk("conflict_drain", 64'(bus.halt), 64'd1);
        chk("conflict_status", 64'(bus.status), 64'd2);
        wait_done("conflict_done");
        chk("conflict_lit_cnt", 64'(bus.lit_cnt), 64'd0);
        finish_clear();

        // Timeout with toggling stall
        start_solve();
        send(3'd4, 64'd0);
        n = 0;
        while (!bus.halt && n < 50) begin
            n++;
            bus.stall = ~bus.stall;
            tick();
        end
        chk("timeout_cycles", 64'(n), 64'd10);
        chk("timeout_status", 64'(bus.status), 64'd3);
        wait_done("timeout_done");
        finish_clear();

        // Backpressure on the result stream
        bus.stall = 1'b1;
        bus.res_ready = 1'b0;
        load_stack(16'd3); load_stack(16'd4); load_stack(16'd6);
        start_solve();
        send(3'd2, 64'd0);
        send(3'd4, 64'd0);
        wait_halt("bp_drain");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_no_pop", 64'(bus.mstack_pop), 64'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_lit_cnt", 64'(bus.lit_cnt), 64'd3);
        chk("bp_res_empty", 64'(exp_res.size()), 64'd0);
        finish_clear();

        // Illegal command, then reset in the middle of DRAIN
        bus.res_ready = 1'b0;
        load_stack(16'd1); load_stack(16'd2);
        start_solve();
        send(3'd6, 64'h55);
        chk("bad_cmd_set", 64'(bus.bad_cmd), 64'd1);
        send(3'd0, 64'h1234);
        send(3'd4, 64'd0);
        chk("bad_cmd_sticky", 64'(bus.bad_cmd), 64'd1);
        wait_halt("rst_drain");
        chk("rst_pre_valid", 64'(bus.res_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        bus.res_ready = 1'b1;
        #1;
        chk("mid_rst_pop", 64'(bus.mstack_pop), 64'd0);
        chk("mid_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_halt", 64'(bus.halt), 64'd1);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
        chk("mid_rst_status", 64'(bus.status), 64'd1 - 64'd1);
        chk("mid_rst_bad", 64'(bus.bad_cmd), 64'd0);
        chk("mid_rst_lit_cnt", 64'(bus.lit_cnt), 64'd0);
        chk("mid_rst_node", 64'(bus.node_in), 64'd0);
        chk("mid_rst_ptr", 64'(bus.dummy_ptr), 64'd0);
        chk("mid_rst_lit", 64'(bus.mem2uca), 64'd0);
        rst_n = 1'b1;
        stk.delete();
        exp_res.delete();
        refresh_stack();
        tick();
        chk("post_rst_idle_halt", 64'(bus.halt), 64'd1);
        chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
